// File: rtl/axi_dma_b_tracker.sv
// Write-completion tracker: tags each issued AW burst with {chan, last}, matches B responses
// in order and reports per-channel transfer completion with sticky error status.
module axi_dma_b_tracker #(
  parameter int unsigned NumChannels = 2,
  parameter int unsigned TagDepth    = 8,
  localparam int unsigned ChanW      = (NumChannels > 1) ? $clog2(NumChannels) : 1,
  localparam int unsigned CntW       = $clog2(TagDepth + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,

  input  logic                   aw_valid_i,
  input  logic [ChanW-1:0]       aw_chan_i,
  input  logic                   aw_last_i,
  output logic                   aw_ready_o,

  output logic                   axi_aw_valid_o,
  input  logic                   axi_aw_ready_i,

  input  logic                   axi_b_valid_i,
  input  logic [1:0]             axi_b_resp_i,
  output logic                   axi_b_ready_o,

  output logic                   done_valid_o,
  output logic [ChanW-1:0]       done_chan_o,
  output logic                   done_error_o,

  output logic [CntW-1:0]        outstanding_o,
  output logic [NumChannels-1:0] chan_busy_o,
  output logic                   idle_o
);

  localparam int unsigned PtrW = $clog2(TagDepth);

  // Tag store
  logic [ChanW-1:0] tag_chan_q [TagDepth];
  logic             tag_last_q [TagDepth];

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  fill_q, fill_d;

  logic [CntW-1:0]        cnt_q [NumChannels];
  logic [CntW-1:0]        cnt_d [NumChannels];
  logic [NumChannels-1:0] err_q, err_d;

  logic             done_valid_q, done_valid_d;
  logic [ChanW-1:0] done_chan_q, done_chan_d;
  logic             done_error_q, done_error_d;

  logic             full, empty, push, pop;
  logic [ChanW-1:0] head_chan;
  logic             head_last;
  logic             head_err;
  logic             b_err;

  // Only resp[1] distinguishes SLVERR/DECERR from OKAY/EXOKAY.
  logic unused_resp;
  assign unused_resp = axi_b_resp_i[0];

  assign full  = (fill_q == CntW'(TagDepth));
  assign empty = (fill_q == '0);

  // Full gates AW regardless of a same-cycle pop, keeping B off the AW path.
  assign axi_aw_valid_o = aw_valid_i & ~full;
  assign aw_ready_o     = axi_aw_ready_i & axi_aw_valid_o;
  assign axi_b_ready_o  = ~empty;

  assign push = aw_ready_o;
  assign pop  = axi_b_valid_i & ~empty;

  assign head_chan = tag_chan_q[rd_ptr_q];
  assign head_last = tag_last_q[rd_ptr_q];
  assign b_err     = axi_b_resp_i[1];

  always_comb begin
    head_err = 1'b0;
    for (int unsigned c = 0; c < NumChannels; c++) begin
      if (head_chan == ChanW'(c)) begin
        head_err = err_q[c];
      end
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    fill_d   = fill_q + CntW'(push) - CntW'(pop);
  end

  always_comb begin
    for (int unsigned c = 0; c < NumChannels; c++) begin
      cnt_d[c] = cnt_q[c];
      if (push && (aw_chan_i == ChanW'(c)) && !(pop && (head_chan == ChanW'(c)))) begin
        cnt_d[c] = cnt_q[c] + CntW'(1);
      end else if (pop && (head_chan == ChanW'(c)) && !(push && (aw_chan_i == ChanW'(c)))) begin
        cnt_d[c] = cnt_q[c] - CntW'(1);
      end
    end
  end

  always_comb begin
    err_d        = err_q;
    done_valid_d = 1'b0;
    done_chan_d  = done_chan_q;
    done_error_d = done_error_q;
    if (pop) begin
      if (head_last) begin
        done_valid_d = 1'b1;
        done_chan_d  = head_chan;
        done_error_d = head_err | b_err;
      end
      for (int unsigned c = 0; c < NumChannels; c++) begin
        if (head_chan == ChanW'(c)) begin
          err_d[c] = head_last ? 1'b0 : (err_q[c] | b_err);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fill_q       <= '0;
      err_q        <= '0;
      done_valid_q <= 1'b0;
      done_chan_q  <= '0;
      done_error_q <= 1'b0;
      for (int unsigned c = 0; c < NumChannels; c++) begin
        cnt_q[c] <= '0;
      end
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fill_q       <= fill_d;
      err_q        <= err_d;
      done_valid_q <= done_valid_d;
      done_chan_q  <= done_chan_d;
      done_error_q <= done_error_d;
      for (int unsigned c = 0; c < NumChannels; c++) begin
        cnt_q[c] <= cnt_d[c];
      end
    end
  end

  // Storage needs no reset; entries are only read between push and pop.
  always_ff @(posedge clk_i) begin
    if (push) begin
      tag_chan_q[wr_ptr_q] <= aw_chan_i;
      tag_last_q[wr_ptr_q] <= aw_last_i;
    end
  end

  always_comb begin
    for (int unsigned c = 0; c < NumChannels; c++) begin
      chan_busy_o[c] = (cnt_q[c] != '0);
    end
  end

  assign done_valid_o  = done_valid_q;
  assign done_chan_o   = done_chan_q;
  assign done_error_o  = done_error_q;
  assign outstanding_o = fill_q;
  assign idle_o        = empty & ~done_valid_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i && push) begin
      assert (int'(aw_chan_i) < int'(NumChannels))
      else $error("aw_chan_i out of range on push");
    end
  end

endmodule

// File: tb/tb_axi_dma_b_tracker.sv
// Randomized and directed bench for axi_dma_b_tracker against a queue-based completion model.
module tb_axi_dma_b_tracker;

  localparam int NumChannels = 2;
  localparam int TagDepth    = 8;
  localparam int ChanW       = 1;
  localparam int CntW        = 4;

  typedef struct {
    int chan;
    bit last;
  } tag_t;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   aw_valid = 1'b0;
  logic [ChanW-1:0]       aw_chan = '0;
  logic                   aw_last = 1'b0;
  logic                   aw_ready;
  logic                   axi_aw_valid;
  logic                   axi_aw_ready = 1'b0;
  logic                   axi_b_valid = 1'b0;
  logic [1:0]             axi_b_resp = '0;
  logic                   axi_b_ready;
  logic                   done_valid;
  logic [ChanW-1:0]       done_chan;
  logic                   done_error;
  logic [CntW-1:0]        outstanding;
  logic [NumChannels-1:0] chan_busy;
  logic                   idle;

  always #5 clk = ~clk;

  axi_dma_b_tracker #(
    .NumChannels(NumChannels),
    .TagDepth   (TagDepth)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .aw_valid_i    (aw_valid),
    .aw_chan_i     (aw_chan),
    .aw_last_i     (aw_last),
    .aw_ready_o    (aw_ready),
    .axi_aw_valid_o(axi_aw_valid),
    .axi_aw_ready_i(axi_aw_ready),
    .axi_b_valid_i (axi_b_valid),
    .axi_b_resp_i  (axi_b_resp),
    .axi_b_ready_o (axi_b_ready),
    .done_valid_o  (done_valid),
    .done_chan_o   (done_chan),
    .done_error_o  (done_error),
    .outstanding_o (outstanding),
    .chan_busy_o   (chan_busy),
    .idle_o        (idle)
  );

  int vectors = 0;
  int errors  = 0;

  // Reference model: outstanding bursts in issue order plus per-channel pending error.
  tag_t mq[$];
  bit   merr [NumChannels];
  bit   exp_done;
  int   exp_chan;
  bit   exp_err;

  logic c_awv, c_awr, c_br;
  bit   e_awv, e_awr, e_br;

  function automatic logic [NumChannels-1:0] model_busy();
    logic [NumChannels-1:0] b = '0;
    foreach (mq[i]) b[mq[i].chan] = 1'b1;
    return b;
  endfunction

  // One clock: drive at posedge+1, sample combinational outputs 1ns later, advance the model.
  task automatic step(input bit awv, input int ch, input bit last, input bit awr,
                      input bit bv, input logic [1:0] resp);
    bit   push, pop;
    tag_t t;
    aw_valid     = awv;
    aw_chan      = ch[ChanW-1:0];
    aw_last      = last;
    axi_aw_ready = awr;
    axi_b_valid  = bv;
    axi_b_resp   = resp;
    #1;
    c_awv = axi_aw_valid;
    c_awr = aw_ready;
    c_br  = axi_b_ready;
    e_awv = awv && (mq.size() < TagDepth);
    e_awr = e_awv && awr;
    e_br  = (mq.size() > 0);
    push  = e_awr;
    pop   = bv && e_br;
    @(posedge clk);
    #1;
    exp_done = 1'b0;
    if (pop) begin
      t = mq.pop_front();
      if (t.last) begin
        exp_done     = 1'b1;
        exp_chan     = t.chan;
        exp_err      = merr[t.chan] | resp[1];
        merr[t.chan] = 1'b0;
      end else begin
        merr[t.chan] = merr[t.chan] | resp[1];
      end
    end
    if (push) begin
      t.chan = ch;
      t.last = last;
      mq.push_back(t);
    end
  endtask

  task automatic do_reset();
    aw_valid = 1'b0; aw_chan = '0; aw_last = 1'b0;
    axi_aw_ready = 1'b0; axi_b_valid = 1'b0; axi_b_resp = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    foreach (merr[i]) merr[i] = 1'b0;
    exp_done = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({done_valid, done_chan, done_error, outstanding, chan_busy, idle, axi_b_ready} !==
        {1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got %b want %b",
               {done_valid, done_chan, done_error, outstanding, chan_busy, idle, axi_b_ready},
               {1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 1'b1, 1'b0});
    end
    aw_valid = 1'b1; axi_aw_ready = 1'b1;
    #1;
    vectors++;
    if ({axi_aw_valid, aw_ready} !== 2'b11) begin
      errors++;
      $display("FAIL reset_aw_comb: got %b want 11", {axi_aw_valid, aw_ready});
    end
    aw_valid = 1'b0; axi_aw_ready = 1'b0;
  endtask

  task automatic test_single_channel();
    bit awv_t [6] = '{1, 1, 1, 0, 0, 0};
    bit lst_t [6] = '{0, 0, 1, 0, 0, 0};
    bit bv_t  [6] = '{0, 0, 0, 1, 1, 1};
    int out_t [6] = '{1, 2, 3, 2, 1, 0};
    bit dv_t  [6] = '{0, 0, 0, 0, 0, 1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(awv_t[i], 0, lst_t[i], 1'b1, bv_t[i], 2'b00);
      vectors++;
      if (outstanding !== CntW'(out_t[i])) begin
        errors++;
        $display("FAIL single_outstanding[%0d]: got %0d want %0d", i, outstanding, out_t[i]);
      end
      vectors++;
      if (done_valid !== dv_t[i]) begin
        errors++;
        $display("FAIL single_done_valid[%0d]: got %0d want %0d", i, done_valid, dv_t[i]);
      end
    end
    vectors++;
    if ({done_chan, done_error, idle} !== 3'b000) begin
      errors++;
      $display("FAIL single_done_info: got %b want 000", {done_chan, done_error, idle});
    end
    step(1'b0, 0, 1'b0, 1'b0, 1'b0, 2'b00);
    vectors++;
    if ({done_valid, idle} !== 2'b01) begin
      errors++;
      $display("FAIL single_idle_return: got %b want 01", {done_valid, idle});
    end
  endtask

  task automatic test_error_sticky();
    do_reset();
    step(1'b1, 1, 1'b0, 1'b1, 1'b0, 2'b00);
    step(1'b1, 1, 1'b1, 1'b1, 1'b0, 2'b00);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1, 2'b10);
    vectors++;
    if (done_valid !== 1'b0) begin
      errors++;
      $display("FAIL sticky_no_early_done: got %0d want 0", done_valid);
    end
    step(1'b0, 0, 1'b0, 1'b0, 1'b1, 2'b00);
    vectors++;
    if ({done_valid, done_chan, done_error} !== 3'b111) begin
      errors++;
      $display("FAIL sticky_err_done: got %b want 111", {done_valid, done_chan, done_error});
    end
    step(1'b1, 1, 1'b1, 1'b1, 1'b0, 2'b00);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1, 2'b00);
    vectors++;
    if ({done_valid, done_chan, done_error} !== 3'b110) begin
      errors++;
      $display("FAIL sticky_cleared: got %b want 110", {done_valid, done_chan, done_error});
    end
    step(1'b1, 0, 1'b1, 1'b1, 1'b0, 2'b00);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1, 2'b11);
    vectors++;
    if ({done_valid, done_chan, done_error} !== 3'b101) begin
      errors++;
      $display("FAIL decerr_last: got %b want 101", {done_valid, done_chan, done_error});
    end
    step(1'b1, 0, 1'b1, 1'b1, 1'b0, 2'b00);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1, 2'b01);
    vectors++;
    if ({done_valid, done_chan, done_error} !== 3'b100) begin
      errors++;
      $display("FAIL exokay_clean: got %b want 100", {done_valid, done_chan, done_error});
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < TagDepth; i++) step(1'b1, 0, 1'b1, 1'b1, 1'b0, 2'b00);
    vectors++;
    if (outstanding !== CntW'(TagDepth)) begin
      errors++;
      $display("FAIL full_outstanding: got %0d want %0d", outstanding, TagDepth);
    end
    step(1'b1, 0, 1'b1, 1'b1, 1'b0, 2'b00);
    vectors++;
    if ({c_awv, c_awr, outstanding} !== {1'b0, 1'b0, 4'd8}) begin
      errors++;
      $display("FAIL full_blocks_aw: got %b want 00_1000", {c_awv, c_awr, outstanding});
    end
    step(1'b1, 0, 1'b1, 1'b1, 1'b1, 2'b00);
    vectors++;
    if ({c_awv, c_br, outstanding, done_valid} !== {1'b0, 1'b1, 4'd7, 1'b1}) begin
      errors++;
      $display("FAIL full_pop_no_bypass: got %b want 01_0111_1",
               {c_awv, c_br, outstanding, done_valid});
    end
    step(1'b1, 0, 1'b1, 1'b1, 1'b0, 2'b00);
    vectors++;
    if ({c_awv, c_awr, outstanding} !== {1'b1, 1'b1, 4'd8}) begin
      errors++;
      $display("FAIL full_release_aw: got %b want 11_1000", {c_awv, c_awr, outstanding});
    end
  endtask

  task automatic test_interleaved();
    bit         awv_t [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    int         ch_t  [8] = '{0, 1, 0, 1, 0, 0, 0, 0};
    bit         lst_t [8] = '{0, 0, 1, 1, 0, 0, 0, 0};
    bit         bv_t  [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    logic [1:0] bsy_t [8] = '{2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b00};
    bit         dv_t  [8] = '{0, 0, 0, 0, 0, 0, 1, 1};
    int         dc_t  [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(awv_t[i], ch_t[i], lst_t[i], 1'b1, bv_t[i], 2'b00);
      vectors++;
      if (chan_busy !== bsy_t[i]) begin
        errors++;
        $display("FAIL inter_busy[%0d]: got %b want %b", i, chan_busy, bsy_t[i]);
      end
      vectors++;
      if (done_valid !== dv_t[i]) begin
        errors++;
        $display("FAIL inter_done_valid[%0d]: got %0d want %0d", i, done_valid, dv_t[i]);
      end
      if (dv_t[i]) begin
        vectors++;
        if (done_chan !== ChanW'(dc_t[i])) begin
          errors++;
          $display("FAIL inter_done_chan[%0d]: got %0d want %0d", i, done_chan, dc_t[i]);
        end
      end
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    step(1'b1, 0, 1'b0, 1'b1, 1'b0, 2'b00);
    step(1'b1, 0, 1'b1, 1'b1, 1'b1, 2'b00);
    vectors++;
    if ({outstanding, chan_busy, done_valid} !== {4'd1, 2'b01, 1'b0}) begin
      errors++;
      $display("FAIL same_chan_push_pop: got %b want 0001_01_0", {outstanding, chan_busy, done_valid});
    end
    step(1'b1, 1, 1'b1, 1'b1, 1'b1, 2'b00);
    vectors++;
    if ({outstanding, chan_busy, done_valid, done_chan} !== {4'd1, 2'b10, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL diff_chan_push_pop: got %b want 0001_10_1_0",
               {outstanding, chan_busy, done_valid, done_chan});
    end
    do_reset();
    step(1'b0, 0, 1'b0, 1'b0, 1'b1, 2'b10);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1, 2'b10);
    vectors++;
    if ({c_br, outstanding, done_valid} !== {1'b0, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL empty_b_held: got %b want 0_0000_0", {c_br, outstanding, done_valid});
    end
    step(1'b1, 1, 1'b1, 1'b1, 1'b1, 2'b00);
    vectors++;
    if ({c_br, outstanding} !== {1'b0, 4'd1}) begin
      errors++;
      $display("FAIL push_not_yet_poppable: got %b want 0_0001", {c_br, outstanding});
    end
    step(1'b0, 0, 1'b0, 1'b0, 1'b1, 2'b00);
    vectors++;
    if ({c_br, done_valid, done_chan, done_error, outstanding} !== {1'b1, 1'b1, 1'b1, 1'b0, 4'd0})
    begin
      errors++;
      $display("FAIL held_b_accepted: got %b want 1_1_1_0_0000",
               {c_br, done_valid, done_chan, done_error, outstanding});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 1, 1'b0, 1'b1, 1'b0, 2'b00);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1, 2'b10);
    vectors++;
    if (outstanding !== 4'd5) begin
      errors++;
      $display("FAIL mid_pre_reset_outstanding: got %0d want 5", outstanding);
    end
    do_reset();
    vectors++;
    if ({done_valid, done_chan, done_error, outstanding, chan_busy, idle, axi_b_ready} !==
        {1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset_state: got %b want %b",
               {done_valid, done_chan, done_error, outstanding, chan_busy, idle, axi_b_ready},
               {1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 1'b1, 1'b0});
    end
    step(1'b1, 1, 1'b1, 1'b1, 1'b0, 2'b00);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1, 2'b00);
    vectors++;
    if ({done_valid, done_chan, done_error} !== 3'b110) begin
      errors++;
      $display("FAIL mid_err_cleared: got %b want 110", {done_valid, done_chan, done_error});
    end
  endtask

  task automatic test_random();
    int aw_pct [3] = '{80, 50, 20};
    int b_pct  [3] = '{30, 50, 90};
    do_reset();
    for (int ph = 0; ph < 3; ph++) begin
      for (int n = 0; n < 700; n++) begin
        step($urandom_range(99) < aw_pct[ph], $urandom_range(NumChannels - 1),
             $urandom_range(2) == 0, $urandom_range(3) != 0,
             $urandom_range(99) < b_pct[ph], 2'($urandom_range(3)));
        vectors++;
        if ({c_awv, c_awr, c_br} !== {e_awv, e_awr, e_br}) begin
          errors++;
          $display("FAIL rand_comb[%0d.%0d]: got %b want %b", ph, n,
                   {c_awv, c_awr, c_br}, {e_awv, e_awr, e_br});
        end
        vectors++;
        if (done_valid !== exp_done) begin
          errors++;
          $display("FAIL rand_done_valid[%0d.%0d]: got %0d want %0d", ph, n, done_valid, exp_done);
        end
        if (exp_done) begin
          vectors++;
          if ({done_chan, done_error} !== {ChanW'(exp_chan), exp_err}) begin
            errors++;
            $display("FAIL rand_done_info[%0d.%0d]: got chan %0d err %0d want chan %0d err %0d",
                     ph, n, done_chan, done_error, exp_chan, exp_err);
          end
        end
        vectors++;
        if (outstanding !== CntW'(mq.size())) begin
          errors++;
          $display("FAIL rand_outstanding[%0d.%0d]: got %0d want %0d", ph, n, outstanding, mq.size());
        end
        vectors++;
        if (chan_busy !== model_busy()) begin
          errors++;
          $display("FAIL rand_busy[%0d.%0d]: got %b want %b", ph, n, chan_busy, model_busy());
        end
        vectors++;
        if (idle !== ((mq.size() == 0) && !exp_done)) begin
          errors++;
          $display("FAIL rand_idle[%0d.%0d]: got %0d want %0d", ph, n, idle,
                   (mq.size() == 0) && !exp_done);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_channel();
    test_error_sticky();
    test_full();
    test_interleaved();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
